// File: rtl/weight_pkg.sv
// Shared types and constants for the weight store: FSM states, LFSR geometry.
package weight_pkg;

    localparam int unsigned W_DEFAULT = 10;
    localparam int unsigned LFSR_W    = 16;
    // Fibonacci taps 16,14,13,11 expressed as state bits 15,13,12,10
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_DONE
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/weight_lfsr.sv
// 16-bit Fibonacci LFSR; resets or loads to SEED, steps only when enabled.
module weight_lfsr
    import weight_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              Clock,
    input  logic              Rst,
    input  logic              Enable,
    input  logic              Load,
    output logic [LFSR_W-1:0] State
);

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst)
            State <= SEED;
        else if (Load)
            State <= SEED;
        else if (Enable)
            State <= lfsr_next(State);
    end

endmodule

// File: rtl/weight_store.sv
// Multi-lane weight memory with bulk zero/random initialisation and range-checked access.
module weight_store
    import weight_pkg::*;
#(
    parameter int unsigned W     = W_DEFAULT,
    parameter int unsigned DEPTH = 65,
    parameter int unsigned N     = 10,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic                     Clock,
    input  logic                     Rst,
    input  logic                     InitReq,
    input  logic                     InitMode,
    input  logic [$clog2(DEPTH)-1:0] Addr,
    input  logic                     WE,
    input  logic                     RE,
    input  logic [N*W-1:0]           D,
    output logic [N*W-1:0]           Q,
    output logic                     QValid,
    output logic                     Busy,
    output logic                     InitDone,
    output logic                     AddrErr
);

    localparam int unsigned AW = $clog2(DEPTH);
    // wide enough for the largest Addr plus N-1 without wrapping
    localparam int unsigned IW = $clog2((2 ** AW) + N);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    state_t            state;
    logic [AW-1:0]     cnt;
    logic              fill_rand;
    logic [LFSR_W-1:0] lfsr_q;
    logic [W-1:0]      mem [DEPTH];

    logic [IW-1:0]     lane_idx [N];
    logic              lane_ok  [N];

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            lane_idx[i] = IW'(Addr) + IW'(i);
            lane_ok[i]  = (lane_idx[i] <= LAST_IDX);
        end
    end

    weight_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .Clock  (Clock),
        .Rst    (Rst),
        .Enable (state == ST_INIT && fill_rand),
        .Load   (1'b0),
        .State  (lfsr_q)
    );

    generate
        if (W < LFSR_W) begin : g_lfsr_spare
            logic lfsr_unused;
            assign lfsr_unused = ^lfsr_q[LFSR_W-1:W];
        end
    endgenerate

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            fill_rand <= 1'b0;
            Busy      <= 1'b0;
            InitDone  <= 1'b0;
            QValid    <= 1'b0;
            AddrErr   <= 1'b0;
            Q         <= '0;
        end else begin
            QValid   <= 1'b0;
            AddrErr  <= 1'b0;
            InitDone <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (WE || RE) begin
                        AddrErr <= !lane_ok[N-1];
                        if (!WE) begin
                            QValid <= 1'b1;
                            for (int unsigned i = 0; i < N; i++)
                                Q[i*W +: W] <= lane_ok[i] ? mem[lane_idx[i][AW-1:0]] : '0;
                        end
                    end
                    if (InitReq) begin
                        state     <= ST_INIT;
                        Busy      <= 1'b1;
                        cnt       <= '0;
                        fill_rand <= InitMode;
                    end
                end
                ST_INIT: begin
                    if (cnt == AW'(DEPTH - 1)) begin
                        state    <= ST_DONE;
                        Busy     <= 1'b0;
                        InitDone <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            for (int unsigned j = 0; j < DEPTH; j++)
                mem[j] <= '0;
        end else if (state == ST_INIT) begin
            mem[cnt] <= fill_rand ? lfsr_q[W-1:0] : '0;
        end else if (state == ST_IDLE && WE) begin
            for (int unsigned i = 0; i < N; i++)
                if (lane_ok[i])
                    mem[lane_idx[i][AW-1:0]] <= D[i*W +: W];
        end
    end

endmodule

// File: tb/tb_weight_store.sv
// Randomised bench for weight_store against a word-array model, plus pinned literal cases.
module tb_weight_store;

    localparam int unsigned W     = 10;
    localparam int unsigned DEPTH = 65;
    localparam int unsigned N     = 10;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic           Clock = 1'b0;
    logic           Rst;
    logic           InitReq, InitMode, WE, RE;
    logic [6:0]     Addr;
    logic [N*W-1:0] D;
    logic [N*W-1:0] Q;
    logic           QValid, Busy, InitDone, AddrErr;

    weight_store #(
        .W     (W),
        .DEPTH (DEPTH),
        .N     (N),
        .SEED  (SEED)
    ) dut (
        .Clock    (Clock),
        .Rst      (Rst),
        .InitReq  (InitReq),
        .InitMode (InitMode),
        .Addr     (Addr),
        .WE       (WE),
        .RE       (RE),
        .D        (D),
        .Q        (Q),
        .QValid   (QValid),
        .Busy     (Busy),
        .InitDone (InitDone),
        .AddrErr  (AddrErr)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: expected output values as seen after each clock edge
    logic [W-1:0]   m_mem [DEPTH];
    logic [N*W-1:0] e_q;
    bit             e_qv, e_ae, e_busy, e_done;
    int             init_pos;
    bit             init_rand;
    logic [15:0]    m_lfsr;

    function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
        e_q = '0; e_qv = 0; e_ae = 0; e_busy = 0; e_done = 0;
        init_pos = 0; init_rand = 0; m_lfsr = SEED;
    endtask

    task automatic model_step();
        int a;
        a = int'(Addr);
        e_qv = 0;
        e_ae = 0;
        if (e_busy) begin
            m_mem[init_pos] = init_rand ? m_lfsr[W-1:0] : '0;
            if (init_rand) m_lfsr = ref_lfsr(m_lfsr);
            init_pos++;
            if (init_pos == DEPTH) begin
                e_busy = 0;
                e_done = 1;
            end
        end else if (e_done) begin
            e_done = 0;
        end else begin
            if (WE || RE) begin
                e_ae = (a + N - 1 > DEPTH - 1);
                if (WE) begin
                    for (int i = 0; i < N; i++)
                        if (a + i < DEPTH) m_mem[a + i] = D[i*W +: W];
                end else begin
                    for (int i = 0; i < N; i++)
                        e_q[i*W +: W] = (a + i < DEPTH) ? m_mem[a + i] : '0;
                    e_qv = 1;
                end
            end
            if (InitReq) begin
                e_busy    = 1;
                init_pos  = 0;
                init_rand = InitMode;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge Clock or posedge Rst);
            if (Rst) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge Clock);
            chk("q", Q, e_q);
            chk("qvalid", QValid, e_qv);
            chk("addrerr", AddrErr, e_ae);
            chk("busy", Busy, e_busy);
            chk("initdone", InitDone, e_done);
        end
    end

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic op(input bit we, input bit re, input int a, input logic [N*W-1:0] d);
        WE = we; RE = re; Addr = 7'(a); D = d;
        cyc();
        WE = 0; RE = 0;
    endtask

    function automatic logic [N*W-1:0] lanes_seq(input int start);
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'(start + i);
        return v;
    endfunction

    function automatic logic [N*W-1:0] lanes_const(input int val);
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'(val);
        return v;
    endfunction

    task automatic run_init(input bit mode, output int busy_cycles);
        busy_cycles = 0;
        InitReq = 1; InitMode = mode;
        cyc();
        InitReq = 0;
        while (Busy && busy_cycles < 200) begin
            busy_cycles++;
            cyc();
        end
    endtask

    initial begin
        logic [N*W-1:0] exp_v;
        logic [N*W-1:0] rnd;
        int bc;
        int r;

        Rst = 1; InitReq = 0; InitMode = 0; WE = 0; RE = 0; Addr = '0; D = '0;
        repeat (3) @(posedge Clock);
        #1 Rst = 0;

        // reset state, read of word 0
        op(0, 1, 0, '0);
        chk("rst_read_q", Q, '0);
        chk("rst_read_qv", QValid, 1);
        chk("rst_read_ae", AddrErr, 0);
        cyc();
        chk("rst_read_qv_pulse", QValid, 0);

        // in-range write then readback
        op(1, 0, 5, lanes_seq(1));
        chk("wr5_qv", QValid, 0);
        op(0, 1, 5, '0);
        chk("rd5_q", Q, lanes_seq(1));
        chk("rd5_qv", QValid, 1);
        cyc();
        chk("rd5_qv_pulse", QValid, 0);

        // write crossing the top of memory: truncated, no wrap
        op(1, 0, 60, lanes_seq(1));
        chk("wr60_ae", AddrErr, 1);
        op(0, 1, 60, '0);
        exp_v = '0;
        for (int i = 0; i < 5; i++) exp_v[i*W +: W] = W'(i + 1);
        chk("rd60_q", Q, exp_v);
        chk("rd60_ae", AddrErr, 1);
        op(0, 1, 0, '0);
        chk("rd0_no_wrap", Q[W-1:0], '0);

        // simultaneous WE and RE is a write only
        op(1, 1, 0, lanes_const(7));
        chk("were_qv", QValid, 0);
        op(0, 1, 0, '0);
        chk("were_rd_q", Q, lanes_const(7));

        // random fill, with a read attempt while busy
        bc = 0;
        InitReq = 1; InitMode = 1;
        cyc();
        InitReq = 0;
        while (Busy && bc < 200) begin
            bc++;
            RE = (bc == 3);
            Addr = '0;
            cyc();
            if (bc == 3) chk("busy_re_qv", QValid, 0);
        end
        RE = 0;
        chk("init_busy_len", bc, 65);
        chk("init_done_pulse", InitDone, 1);
        cyc();
        chk("init_done_clear", InitDone, 0);
        op(0, 1, 0, '0);
        chk("rand_word0", Q[0 +: W], 10'h0E1);
        chk("rand_word1", Q[W +: W], 10'h1C3);
        for (int a = 10; a <= 60; a += 10) op(0, 1, a, '0);

        // second random fill continues the sequence
        run_init(1, bc);
        chk("init2_busy_len", bc, 65);
        for (int a = 0; a <= 60; a += 10) op(0, 1, a, '0);

        // reset in the middle of an init
        InitReq = 1; InitMode = 1;
        cyc();
        InitReq = 0;
        repeat (30) cyc();
        Rst = 1;
        #1;
        chk("abort_busy", Busy, 0);
        repeat (2) @(posedge Clock);
        #1 Rst = 0;
        repeat (80) begin
            cyc();
            if (InitDone) chk("abort_no_done", InitDone, 0);
        end
        for (int a = 0; a <= 60; a += 10) begin
            op(0, 1, a, '0);
            chk("abort_zero", Q, '0);
        end

        // randomised traffic
        for (int c = 0; c < 1500; c++) begin
            r = $urandom_range(0, 99);
            InitReq  = (r < 2);
            InitMode = 1'($urandom_range(0, 1));
            WE = (r >= 3 && r <= 30);
            RE = (r >= 20 && r <= 55);
            Addr = ($urandom_range(0, 1) != 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(50, 70));
            for (int i = 0; i < N; i++) rnd[i*W +: W] = W'($urandom);
            D = rnd;
            cyc();
        end
        InitReq = 0; WE = 0; RE = 0;
        repeat (80) cyc();
        for (int a = 0; a <= 60; a += 10) op(0, 1, a, '0);
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
